apb_slave_regfile: RTL and testbench



---
 rtl/apb_slave_regfile.sv | 153 +++++++++++++++
 tb/tb_apb_slave_regfile.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regfile.sv
// APB2 slave with a 16x32 register bank, phase tracking and
// sticky protocol-violation flag; word 15 is a read-only status.
module apb_slave_regfile #(
  parameter int unsigned SEL_INDEX = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [2:0]  psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] pr_data,
  output logic        slv_err,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] prd_q, prd_d;
  logic        err_q, err_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [15:0] rcnt_q, rcnt_d;
  logic [31:0] bank_q [16];

  logic        sel;
  logic        latch;
  logic        commit;
  logic [3:0]  aidx;
  logic [31:0] rword;
  logic        unused_ok;

  assign sel   = psel[SEL_INDEX];
  assign aidx  = paddr[5:2];
  assign rword = (aidx == 4'hF) ? {wcnt_q, rcnt_q}
                                : bank_q[aidx];
  assign unused_ok = ^{paddr[31:6], paddr[1:0], psel};

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdat_d  = wdat_q;
    prd_d   = prd_q;
    err_d   = err_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    latch   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          sel && !penable: begin
            latch   = 1'b1;
            state_d = SETUP;
          end
          sel && penable: err_d = 1'b1;
          default: ;
        endcase
      end
      SETUP: begin
        unique case (1'b1)
          !sel: begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
          sel && penable: begin
            state_d = ACCESS;
            commit  = 1'b1;
            if (pwrite != wr_q || aidx != idx_q)
              err_d = 1'b1;
          end
          default: begin
            err_d = 1'b1;
            latch = 1'b1;
          end
        endcase
      end
      ACCESS: begin
        unique case (1'b1)
          !sel: state_d = IDLE;
          sel && !penable: begin
            latch   = 1'b1;
            state_d = SETUP;
          end
          default: begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
    // Read data is fetched at setup so it is stable through access
    if (latch) begin
      wr_d   = pwrite;
      idx_d  = aidx;
      wdat_d = pwdata;
      if (!pwrite)
        prd_d = rword;
    end
    if (commit) begin
      if (wr_q) wcnt_d = wcnt_q + 16'd1;
      else      rcnt_d = rcnt_q + 16'd1;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      idx_q   <= 4'd0;
      wdat_q  <= 32'd0;
      prd_q   <= 32'd0;
      err_q   <= 1'b0;
      wcnt_q  <= 16'd0;
      rcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      prd_q   <= prd_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      for (int i = 0; i < 16; i++)
        bank_q[i] <= 32'd0;
    end else if (commit && wr_q && idx_q != 4'hF) begin
      bank_q[idx_q] <= wdat_q;
    end
  end

  assign pr_data  = prd_q;
  assign slv_err  = err_q;
  assign wr_count = wcnt_q;
  assign rd_count = rcnt_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile: stimulus pushes expected
// values, a negedge monitor pops and compares them.
module tb_apb_slave_regfile;

  localparam int SEL = 0;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] pr_data;
  logic        slv_err;
  logic [15:0] wr_count;
  logic [15:0] rd_count;

  apb_slave_regfile #(.SEL_INDEX(SEL)) dut (
    .hclk     (hclk),
    .hreset   (hreset),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pr_data  (pr_data),
    .slv_err  (slv_err),
    .wr_count (wr_count),
    .rd_count (rd_count)
  );

  always #5 hclk = ~hclk;

  typedef struct packed {
    logic [1:0]  what;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  logic chk = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: transfer-level view of the peripheral
  logic [31:0] m_mem [16];
  logic [15:0] m_wc, m_rc;
  logic        m_err;
  logic [31:0] m_pr;

  function automatic logic [31:0] rdval(input int idx);
    return (idx == 15) ? {m_wc, m_rc} : m_mem[idx];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 32'd0;
    m_wc  = 16'd0;
    m_rc  = 16'd0;
    m_err = 1'b0;
    m_pr  = 32'd0;
  endtask

  task automatic m_commit(input logic w, input int idx,
                          input logic [31:0] d);
    if (w) begin
      if (idx != 15) m_mem[idx] = d;
      m_wc++;
    end else begin
      m_rc++;
    end
  endtask

  task automatic push(input logic [1:0] w, input logic [31:0] e);
    q.push_back('{what: w, exp: e});
    chk = 1'b1;
  endtask

  task automatic expect_all();
    push(2'd0, m_pr);
    push(2'd1, {16'd0, m_wc});
    push(2'd2, {16'd0, m_rc});
    push(2'd3, {31'd0, m_err});
  endtask

  always @(negedge hclk) begin
    if (chk) begin
      while (q.size() > 0) begin
        chk_t        it;
        logic [31:0] act;
        string       nm;
        it = q.pop_front();
        case (it.what)
          2'd0: begin act = pr_data;           nm = "pr_data";  end
          2'd1: begin act = {16'd0, wr_count}; nm = "wr_count"; end
          2'd2: begin act = {16'd0, rd_count}; nm = "rd_count"; end
          default: begin act = {31'd0, slv_err}; nm = "slv_err"; end
        endcase
        n_vec++;
        if (act !== it.exp) begin
          n_err++;
          $display("FAIL %s @%0t: got %h expected %h",
                   nm, $time, act, it.exp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge hclk);
    #1;
    chk = 1'b0;
  endtask

  task automatic idle();
    psel    = 3'b000;
    penable = 1'b0;
    cyc();
  endtask

  task automatic setup(input logic [2:0] s, input logic w,
                       input int idx, input logic [31:0] d);
    psel    = s;
    penable = 1'b0;
    pwrite  = w;
    paddr   = $urandom;
    paddr[5:2] = idx[3:0];
    pwdata  = d;
    cyc();
    if (s[SEL] && !w) m_pr = rdval(idx);
  endtask

  task automatic xfer(input logic [2:0] s, input logic w,
                      input int idx, input logic [31:0] d);
    setup(s, w, idx, d);
    penable = 1'b1;
    push(2'd0, m_pr);
    cyc();
    if (s[SEL]) m_commit(w, idx, d);
    expect_all();
  endtask

  task automatic v_early();
    idle();
    psel    = 3'b001;
    penable = 1'b1;
    pwrite  = 1'($urandom_range(0, 1));
    cyc();
    m_err = 1'b1;
    expect_all();
  endtask

  task automatic v_abort(input logic w, input int idx,
                         input logic [31:0] d);
    setup(3'b001, w, idx, d);
    idle();
    m_err = 1'b1;
    expect_all();
  endtask

  task automatic v_mismatch(input logic w, input int idx,
                            input logic [31:0] d);
    int nw, ni;
    setup(3'b001, w, idx, d);
    nw = $urandom_range(0, 1);
    ni = $urandom_range(0, 15);
    pwrite     = nw[0];
    paddr[5:2] = ni[3:0];
    pwdata     = $urandom;
    penable    = 1'b1;
    push(2'd0, m_pr);
    cyc();
    m_commit(w, idx, d);
    if (nw[0] != w || ni != idx) m_err = 1'b1;
    expect_all();
  endtask

  task automatic v_resetup(input logic w, input int idx,
                           input logic [31:0] d);
    setup(3'b001, 1'($urandom_range(0, 1)),
          $urandom_range(0, 15), $urandom);
    m_err = 1'b1;
    xfer(3'b001, w, idx, d);
  endtask

  task automatic v_hold(input logic w, input int idx,
                        input logic [31:0] d);
    xfer(3'b001, w, idx, d);
    cyc();
    m_err = 1'b1;
    expect_all();
  endtask

  task automatic reset_mid(input int idx, input logic [31:0] d);
    setup(3'b001, 1'b1, idx, d);
    penable = 1'b1;
    hreset  = 1'b1;
    cyc();
    hreset  = 1'b0;
    psel    = 3'b000;
    penable = 1'b0;
    m_reset();
    expect_all();
  endtask

  initial begin
    hreset  = 1'b1;
    psel    = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'd0;
    pwdata  = 32'd0;
    m_reset();
    cyc();
    cyc();
    hreset = 1'b0;
    expect_all();
    cyc();

    xfer(3'b001, 1'b1, 2, 32'hDEADBEEF);
    xfer(3'b001, 1'b0, 2, 32'd0);
    idle();

    xfer(3'b001, 1'b1, 0, 32'h1);
    xfer(3'b001, 1'b1, 1, 32'h2);
    xfer(3'b001, 1'b0, 0, 32'd0);
    xfer(3'b001, 1'b0, 1, 32'd0);
    idle();

    xfer(3'b010, 1'b1, 3, 32'hCAFEF00D);
    idle();
    xfer(3'b001, 1'b0, 3, 32'd0);
    idle();

    hreset = 1'b1;
    cyc();
    hreset = 1'b0;
    m_reset();
    expect_all();
    xfer(3'b001, 1'b1, 15, 32'hFFFFFFFF);
    xfer(3'b001, 1'b0, 15, 32'd0);
    xfer(3'b001, 1'b0, 15, 32'd0);
    idle();

    v_early();
    idle();
    xfer(3'b001, 1'b1, 5, 32'h12345678);
    xfer(3'b001, 1'b0, 5, 32'd0);
    idle();

    reset_mid(4, 32'hA5A5A5A5);
    cyc();
    xfer(3'b001, 1'b0, 4, 32'd0);
    idle();

    for (int n = 0; n < 300; n++) begin
      int          k, idx;
      logic        w;
      logic [31:0] d;
      k   = $urandom_range(0, 11);
      idx = ($urandom_range(0, 5) == 0) ? 15 : $urandom_range(0, 15);
      w   = 1'($urandom_range(0, 1));
      d   = $urandom;
      case (k)
        0, 1, 2, 3, 4: xfer(3'b001, w, idx, d);
        5: xfer(($urandom_range(0, 1) != 0) ? 3'b010 : 3'b100,
                w, idx, d);
        6: v_early();
        7: v_abort(w, idx, d);
        8: v_mismatch(w, idx, d);
        9: v_resetup(w, idx, d);
        10: v_hold(w, idx, d);
        default: begin
          if ($urandom_range(0, 3) == 0) reset_mid(idx, d);
          else idle();
        end
      endcase
      if ($urandom_range(0, 3) == 0) idle();
    end

    idle();
    idle();
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left expected 0",
               q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
